// File: rtl/delay_buffer_pkg.sv
// delay_buffer_pkg: shared types and default widths for the delay buffer scheduler
package delay_buffer_pkg;
  localparam int MEM_WIDTH_DEF  = 16;
  localparam int ADDR_WIDTH_DEF = 16;
  typedef enum logic [1:0] {IDLE, WRITE, RD_ISSUE, RD_WAIT} state_e;
  typedef enum logic {GRANT_WRITE, GRANT_READ} grant_e;
endpackage

// File: rtl/delay_buffer_scheduler_if.sv
// delay_buffer_scheduler_if: requester and memory signals of the scheduler; freeze exists only with DELAY_FREEZE_EN
interface delay_buffer_scheduler_if
  import delay_buffer_pkg::*;
#(
  parameter int MEM_WIDTH  = MEM_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
);
  logic                  wr_req;
  logic [MEM_WIDTH-1:0]  wr_data;
  logic                  wr_ack;
  logic                  rd_req;
  logic [MEM_WIDTH-1:0]  rd_data;
  logic                  rd_valid;
  logic [ADDR_WIDTH-1:0] delay;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_we;
  logic [MEM_WIDTH-1:0]  mem_wdata;
  logic [MEM_WIDTH-1:0]  mem_rdata;
  logic [ADDR_WIDTH-1:0] wr_ptr;
`ifdef DELAY_FREEZE_EN
  logic                  freeze;
`endif
  modport slave (
`ifdef DELAY_FREEZE_EN
    input  freeze,
`endif
    input  wr_req, wr_data, rd_req, delay, mem_rdata,
    output wr_ack, rd_data, rd_valid, mem_addr, mem_we, mem_wdata, wr_ptr
  );
  modport master (
`ifdef DELAY_FREEZE_EN
    output freeze,
`endif
    output wr_req, wr_data, rd_req, delay, mem_rdata,
    input  wr_ack, rd_data, rd_valid, mem_addr, mem_we, mem_wdata, wr_ptr
  );
endinterface

// File: rtl/delay_buffer_scheduler_rr_arbiter2.sv
// rr_arbiter2: two-way round-robin picker; a tie goes to the requester not served last
module rr_arbiter2
  import delay_buffer_pkg::*;
(
  input  logic   clk,
  input  logic   reset_n,
  input  logic   wr_req_i,
  input  logic   rd_req_i,
  input  logic   upd_i,
  input  grant_e upd_grant_i,
  output logic   any_o,
  output grant_e grant_o
);
  grant_e last_q;
  // remember who finished last; starting at READ hands the first tie to WRITE
  always_ff @(posedge clk) begin
    if (!reset_n) last_q <= GRANT_READ;
    else if (upd_i) last_q <= upd_grant_i;
  end
  assign any_o   = wr_req_i | rd_req_i;
  assign grant_o = (rd_req_i && (!wr_req_i || last_q == GRANT_WRITE)) ? GRANT_READ : GRANT_WRITE;
endmodule

// File: rtl/delay_buffer_scheduler.sv
// delay_buffer_scheduler: single-port delay buffer controller; DELAY_FREEZE_EN adds a freeze input
module delay_buffer_scheduler
  import delay_buffer_pkg::*;
#(
  parameter int MEM_WIDTH  = MEM_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int RD_LATENCY = 1
) (
  input logic clk,
  input logic reset_n,
  delay_buffer_scheduler_if.slave bus
);
  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [MEM_WIDTH-1:0]  mem_wdata_q, mem_wdata_d;
  logic [MEM_WIDTH-1:0]  rd_data_q, rd_data_d;
  logic                  mem_we_q, mem_we_d;
  logic                  wr_ack_q, wr_ack_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [1:0]            cnt_q, cnt_d;
  logic                  freeze;
  logic                  rd_done;
  logic                  grant_any;
  grant_e                grant_pick;
`ifdef DELAY_FREEZE_EN
  assign freeze = bus.freeze;
`else
  assign freeze = 1'b0;
`endif
  assign rd_done = state_q == RD_WAIT && cnt_q == 2'(RD_LATENCY - 1);
  rr_arbiter2 u_arb (
    .clk         (clk),
    .reset_n     (reset_n),
    .wr_req_i    (bus.wr_req),
    .rd_req_i    (bus.rd_req),
    .upd_i       (state_q == WRITE || rd_done),
    .upd_grant_i (state_q == WRITE ? GRANT_WRITE : GRANT_READ),
    .any_o       (grant_any),
    .grant_o     (grant_pick)
  );
  // next-state and registered outputs; every transaction returns through IDLE
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rd_data_d   = rd_data_q;
    mem_we_d    = 1'b0;
    wr_ack_d    = 1'b0;
    rd_valid_d  = 1'b0;
    cnt_d       = (state_q == RD_WAIT && !rd_done) ? cnt_q + 2'd1 : 2'd0;
    case (state_q)
      IDLE: begin
        if (grant_any && grant_pick == GRANT_WRITE) begin
          state_d     = WRITE;
          mem_addr_d  = wr_ptr_q;
          mem_we_d    = !freeze;
          mem_wdata_d = bus.wr_data;
          wr_ack_d    = 1'b1;
        end else if (grant_any) begin
          state_d    = RD_ISSUE;
          mem_addr_d = wr_ptr_q - bus.delay;
        end
      end
      WRITE: begin
        state_d  = IDLE;
        wr_ptr_d = freeze ? wr_ptr_q : wr_ptr_q + 1'b1;
      end
      RD_ISSUE: state_d = RD_WAIT;
      RD_WAIT: begin
        if (rd_done) begin
          state_d    = IDLE;
          rd_data_d  = bus.mem_rdata;
          rd_valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // state registers; reset drops any transaction in flight without ack or valid
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rd_data_q   <= '0;
      mem_we_q    <= 1'b0;
      wr_ack_q    <= 1'b0;
      rd_valid_q  <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rd_data_q   <= rd_data_d;
      mem_we_q    <= mem_we_d;
      wr_ack_q    <= wr_ack_d;
      rd_valid_q  <= rd_valid_d;
      cnt_q       <= cnt_d;
    end
  end
  assign bus.wr_ack    = wr_ack_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.wr_ptr    = wr_ptr_q;
endmodule
